// File: rtl/spi_word_pkg.sv
// Shared defaults and FSM state encodings for the SPI word-transfer responder.
package spi_word_pkg;

    localparam int WORD_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [7:0] {
        IDLE_st      = 8'd0,
        LOAD_st      = 8'd1,
        WAIT_RISE_st = 8'd2,
        WAIT_FALL_st = 8'd3
    } spi_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Pin synchronizer with one history flop; produces level plus rise/fall strobes.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Synchronizer chain followed by the edge-detection history flop
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/spi_slave_word_transfer.sv
// SPI mode-0 responder: oversampled SCK/SS/MOSI, 16-bit words MSB first,
// back-to-back words without SS toggling, abort pulse on mid-word deselect.
module spi_slave_word_transfer
    import spi_word_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk210_p,
    input  logic              reset_p,
    input  logic              spi_sck_p,
    input  logic              spi_ss_p,
    input  logic              spi_mosi_p,
    output logic              spi_miso_p,
    input  logic [WORD_W-1:0] spi_ltransfer_out_p,
    output logic [WORD_W-1:0] spi_ltransfer_in_p,
    output logic              spi_word_done_p,
    output logic              spi_abort_p,
    output logic              spi_busy_p
);

    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic w_sck_sync, w_sck_rise, w_sck_fall;
    logic w_ss_sync, w_ss_rise, w_ss_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .i_clk(clk210_p), .i_reset(reset_p), .i_pin(spi_sck_p),
        .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .i_clk(clk210_p), .i_reset(reset_p), .i_pin(spi_ss_p),
        .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    // MOSI shares the SCK depth so its level lines up with the detected edge
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .i_clk(clk210_p), .i_reset(reset_p), .i_pin(spi_mosi_p),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = w_sck_sync ^ w_ss_rise ^ w_mosi_rise ^ w_mosi_fall;

    spi_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_shift_in;
    logic [WORD_W-1:0] r_shift_out;
    logic [WORD_W-1:0] r_in_word;
    logic              r_miso;
    logic              r_done;
    logic              r_abort;
    logic              r_busy;
    logic              r_cap_pend;

    // Transfer FSM with all outputs registered
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            r_state     <= IDLE_st;
            r_cnt       <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_in_word   <= '0;
            r_miso      <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_busy      <= 1'b0;
            r_cap_pend  <= 1'b0;
        end else begin
            r_done     <= r_cap_pend;
            r_abort    <= 1'b0;
            r_cap_pend <= 1'b0;
            if (r_cap_pend) begin
                r_in_word <= r_shift_in;
            end
            // Deselect wins over any SCK edge detected in the same cycle
            if ((r_state != IDLE_st) && w_ss_sync) begin
                r_state <= IDLE_st;
                r_cnt   <= '0;
                r_miso  <= 1'b0;
                r_busy  <= 1'b0;
                r_abort <= (r_cnt != '0) && (r_cnt < CNT_FULL);
            end else begin
                case (r_state)
                    IDLE_st: begin
                        r_cnt  <= '0;
                        r_miso <= 1'b0;
                        if (w_ss_fall) begin
                            r_state <= LOAD_st;
                            r_busy  <= 1'b1;
                        end
                    end
                    LOAD_st: begin
                        r_shift_out <= spi_ltransfer_out_p;
                        r_miso      <= spi_ltransfer_out_p[WORD_W-1];
                        r_cnt       <= '0;
                        r_state     <= WAIT_RISE_st;
                    end
                    WAIT_RISE_st: begin
                        if (w_sck_rise) begin
                            r_shift_in <= {r_shift_in[WORD_W-2:0], w_mosi_sync};
                            r_cnt      <= r_cnt + CNT_W'(1);
                            r_cap_pend <= (r_cnt == CNT_LAST);
                            r_state    <= WAIT_FALL_st;
                        end
                    end
                    WAIT_FALL_st: begin
                        if (w_sck_fall) begin
                            if (r_cnt < CNT_FULL) begin
                                r_shift_out <= {r_shift_out[WORD_W-2:0], 1'b0};
                                r_miso      <= r_shift_out[WORD_W-2];
                                r_state     <= WAIT_RISE_st;
                            end else begin
                                r_state <= LOAD_st;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE_st;
                        r_cnt   <= '0;
                        r_miso  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi_miso_p         = r_miso;
    assign spi_ltransfer_in_p = r_in_word;
    assign spi_word_done_p    = r_done;
    assign spi_abort_p        = r_abort;
    assign spi_busy_p         = r_busy;

endmodule

// File: tb/tb_spi_slave_word_transfer.sv
// Self-checking bench: a bit-level SPI master plus a word-level reference model.
module tb_spi_slave_word_transfer;

    logic        clk210_p = 1'b0;
    logic        reset_p = 1'b1;
    logic        spi_sck_p = 1'b0;
    logic        spi_ss_p = 1'b1;
    logic        spi_mosi_p = 1'b0;
    logic        spi_miso_p;
    logic [15:0] spi_ltransfer_out_p = 16'h0000;
    logic [15:0] spi_ltransfer_in_p;
    logic        spi_word_done_p;
    logic        spi_abort_p;
    logic        spi_busy_p;

    spi_slave_word_transfer dut (
        .clk210_p(clk210_p), .reset_p(reset_p),
        .spi_sck_p(spi_sck_p), .spi_ss_p(spi_ss_p), .spi_mosi_p(spi_mosi_p),
        .spi_miso_p(spi_miso_p),
        .spi_ltransfer_out_p(spi_ltransfer_out_p),
        .spi_ltransfer_in_p(spi_ltransfer_in_p),
        .spi_word_done_p(spi_word_done_p), .spi_abort_p(spi_abort_p),
        .spi_busy_p(spi_busy_p)
    );

    always #2 clk210_p = ~clk210_p;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    logic [15:0] done_q[$];

    logic        swap_pending = 1'b0;
    int          swap_base = 0;
    logic [15:0] swap_word = 16'h0000;

    logic [15:0] ref_in = 16'h0000;

    // Pulse monitor, sampled on the inactive clock edge
    always @(negedge clk210_p) begin
        if (spi_word_done_p) begin
            done_cnt++;
            done_q.push_back(spi_ltransfer_in_p);
        end
        if (spi_abort_p) abort_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk210_p);
    endtask

    // Clock n bits MSB-first; MISO sampled just before each rising SCK
    task automatic spi_bits(input logic [15:0] w, input int n, input int half, output logic [15:0] rx);
        rx = 16'h0000;
        for (int i = 0; i < n; i++) begin
            spi_mosi_p = w[15-i];
            wait_cyc(half);
            rx = {rx[14:0], spi_miso_p};
            spi_sck_p = 1'b1;
            for (int k = 0; k < half; k++) begin
                @(negedge clk210_p);
                if (swap_pending && (done_cnt != swap_base)) begin
                    spi_ltransfer_out_p = swap_word;
                    swap_pending = 1'b0;
                end
            end
            spi_sck_p = 1'b0;
        end
    endtask

    // One framed transaction of n bits; the reference model predicts all effects
    task automatic xfer(input string tag, input logic [15:0] mosi_w, input logic [15:0] out_w,
                        input int n, input int half);
        logic [15:0] rx;
        logic [15:0] exp_rx;
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        done_q.delete();
        spi_ltransfer_out_p = out_w;
        spi_ss_p = 1'b0;
        wait_cyc(10);
        spi_bits(mosi_w, n, half, rx);
        wait_cyc(half);
        spi_ss_p = 1'b1;
        wait_cyc(10);
        exp_rx = (n == 16) ? out_w : (out_w >> (16 - n));
        if (n == 16) ref_in = mosi_w;
        check_val({tag, "_miso"}, {16'h0000, rx}, {16'h0000, exp_rx});
        check_val({tag, "_in"}, {16'h0000, spi_ltransfer_in_p}, {16'h0000, ref_in});
        check_val({tag, "_done"}, done_cnt - d0, (n == 16) ? 1 : 0);
        check_val({tag, "_abort"}, abort_cnt - a0, (n > 0 && n < 16) ? 1 : 0);
        check_val({tag, "_idle"}, {30'd0, spi_miso_p, spi_busy_p}, 32'd0);
    endtask

    initial begin
        logic [15:0] rx1, rx2;
        int d0, a0;

        wait_cyc(5);
        check_val("rst_miso", {31'd0, spi_miso_p}, 32'd0);
        check_val("rst_in", {16'd0, spi_ltransfer_in_p}, 32'd0);
        check_val("rst_pulses", {30'd0, spi_word_done_p, spi_abort_p}, 32'd0);
        check_val("rst_busy", {31'd0, spi_busy_p}, 32'd0);
        reset_p = 1'b0;
        wait_cyc(10);

        xfer("single", 16'hA5C3, 16'h3C5A, 16, 50);

        // Back-to-back words; out word swapped right after the first done
        d0 = done_cnt;
        done_q.delete();
        spi_ltransfer_out_p = 16'h1234;
        swap_word = 16'hBEEF;
        swap_base = done_cnt;
        swap_pending = 1'b1;
        spi_ss_p = 1'b0;
        wait_cyc(10);
        spi_bits(16'hFFFF, 16, 50, rx1);
        spi_bits(16'h0001, 16, 50, rx2);
        wait_cyc(50);
        spi_ss_p = 1'b1;
        wait_cyc(10);
        swap_pending = 1'b0;
        ref_in = 16'h0001;
        check_val("b2b_rx1", {16'd0, rx1}, 32'h1234);
        check_val("b2b_rx2", {16'd0, rx2}, 32'hBEEF);
        check_val("b2b_done", done_cnt - d0, 2);
        check_val("b2b_w1", (done_q.size() > 0) ? {16'd0, done_q[0]} : 32'hDEAD_0000, 32'hFFFF);
        check_val("b2b_w2", (done_q.size() > 1) ? {16'd0, done_q[1]} : 32'hDEAD_0000, 32'h0001);

        xfer("abort7", 16'h7E81, 16'hC0DE, 7, 20);

        // SCK activity with SS high must be ignored
        d0 = done_cnt;
        a0 = abort_cnt;
        for (int i = 0; i < 20; i++) begin
            spi_sck_p = 1'b1; wait_cyc(10);
            spi_sck_p = 1'b0; wait_cyc(10);
        end
        check_val("sckhi_quiet", (done_cnt - d0) + (abort_cnt - a0), 0);
        check_val("sckhi_state", {30'd0, spi_miso_p, spi_busy_p}, 32'd0);
        xfer("after_sckhi", 16'h8001, 16'h6A6A, 16, 30);

        // Reset pulsed mid-word after bit 9
        a0 = abort_cnt;
        d0 = done_cnt;
        spi_ltransfer_out_p = 16'h9999;
        spi_ss_p = 1'b0;
        wait_cyc(10);
        spi_bits(16'hABCD, 9, 20, rx1);
        reset_p = 1'b1;
        wait_cyc(1);
        reset_p = 1'b0;
        wait_cyc(5);
        ref_in = 16'h0000;
        check_val("rstmid_in", {16'd0, spi_ltransfer_in_p}, 32'd0);
        check_val("rstmid_pulses", (abort_cnt - a0) + (done_cnt - d0), 0);
        check_val("rstmid_idle", {30'd0, spi_miso_p, spi_busy_p}, 32'd0);
        spi_ss_p = 1'b1;
        wait_cyc(20);
        check_val("rstmid_ss", abort_cnt - a0, 0);
        xfer("after_rst", 16'h00FF, 16'h1357, 16, 25);

        xfer("min_timing", 16'h5555, 16'h5555, 16, 8);

        // Randomized words and aborts against the reference model
        for (int t = 0; t < 10; t++) begin
            int n;
            int half;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
            half = $urandom_range(8, 30);
            xfer($sformatf("rnd%0d", t), 16'($urandom), 16'($urandom), n, half);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
